disp_arbiter: RTL and testbench

- Sequences the shared four-digit 7-segment display between two digit sources: A (e.g. register view) and B (e.g. PC/debug view).
- Arbitrates A/B requests and enforces a minimum hold time per grant.
- Drives the source-select line `off` to the existing 2:1 digit mux.
- Time-multiplexes the four selected nibbles onto one digit bus with active-low anode enables.

---
 rtl/disp_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_disp_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// disp_arbiter
// Arbitrates two digit sources (A, B) for one shared four-digit 7-segment
// display. A grant is held for at least HOLD_CYCLES clocks; once expired, a
// pending request from the other source switches ownership directly. While
// granted, the four nibbles of the selected source are scanned onto one
// digit bus with active-low anode enables.
//
// Optional build macro: DISP_ARBITER_BLANK_LEAD_EN enables leading-zero
// blanking (digit 0 is never blanked).
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   req_a  in   source A request
//   req_b  in   source B request
//   dig_a  in   [15:0] source A digits, nibble k = digit k (k=0 rightmost)
//   dig_b  in   [15:0] source B digits
//   gnt_a  out  A owns the display
//   gnt_b  out  B owns the display
//   off    out  digit mux select (0 = A, 1 = B)
//   an     out  [3:0] active-low digit enables
//   digit  out  [3:0] nibble for the enabled digit
//   busy   out  high in any grant state
module disp_arbiter #(
  parameter int HOLD_CYCLES = 1000,
  parameter int SCAN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] dig_a,
  input  logic [15:0] dig_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        off,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        busy
);

  // Width of 1 is kept for a parameter of 1 so the counters always exist.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [HW-1:0]   hold_r, hold_s;
  logic [SW-1:0]   scan_r, scan_s;
  logic [1:0]      idx_r, idx_s;
  logic            last_r, last_s;   // 1 = B was granted last
  logic            off_s;
  logic            enter_a_s, enter_b_s;
  logic            expired_s;
  logic [15:0]     sel_s;
  logic [3:0]      nib_s;
  logic [3:0]      an_s;

`ifdef DISP_ARBITER_BLANK_LEAD_EN
  // True when digit k and every more-significant digit are zero (k > 0).
  function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] k);
    logic z;
    case (k)
      2'd1:    z = (value[15:4]  == 12'h000);
      2'd2:    z = (value[15:8]  == 8'h00);
      2'd3:    z = (value[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  assign expired_s = (hold_r == HOLD_MAX);

  // Next-state selection and grant-entry detection.
  always_comb begin
    state_s   = state_r;
    enter_a_s = 1'b0;
    enter_b_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_a && req_b) begin
          // Round robin: grant whichever source was not granted last.
          if (last_r) begin
            enter_a_s = 1'b1;
            state_s   = GNT_A;
          end else begin
            enter_b_s = 1'b1;
            state_s   = GNT_B;
          end
        end else if (req_a) begin
          enter_a_s = 1'b1;
          state_s   = GNT_A;
        end else if (req_b) begin
          enter_b_s = 1'b1;
          state_s   = GNT_B;
        end else begin
          state_s = IDLE;
        end
      end
      GNT_A: begin
        // Other source wins once expired, even if A still requests.
        if (expired_s && req_b) begin
          enter_b_s = 1'b1;
          state_s   = GNT_B;
        end else if (expired_s && !req_a) begin
          state_s = IDLE;
        end else begin
          state_s = GNT_A;
        end
      end
      GNT_B: begin
        if (expired_s && req_a) begin
          enter_a_s = 1'b1;
          state_s   = GNT_A;
        end else if (expired_s && !req_b) begin
          state_s = IDLE;
        end else begin
          state_s = GNT_B;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Hold / scan counters, round-robin memory and mux select.
  always_comb begin
    hold_s = hold_r;
    scan_s = scan_r;
    idx_s  = idx_r;
    last_s = last_r;
    off_s  = off;
    if (enter_a_s || enter_b_s) begin
      // Fresh grant (including a direct switch) restarts hold and scan.
      hold_s = '0;
      scan_s = '0;
      idx_s  = 2'd0;
      last_s = enter_b_s;
      off_s  = enter_b_s;
    end else if (state_s != IDLE) begin
      if (hold_r != HOLD_MAX) begin
        hold_s = hold_r + HW'(1);
      end else begin
        hold_s = hold_r;
      end
      if (scan_r == SCAN_MAX) begin
        scan_s = '0;
        idx_s  = idx_r + 2'd1;
      end else begin
        scan_s = scan_r + SW'(1);
        idx_s  = idx_r;
      end
    end else begin
      hold_s = '0;
      scan_s = '0;
      idx_s  = 2'd0;
    end
  end

  // Digit selection and anode decode for the upcoming cycle.
  always_comb begin
    sel_s = off_s ? dig_b : dig_a;
    nib_s = sel_s[{idx_s, 2'b00} +: 4];
    if (state_s == IDLE) begin
      an_s = 4'b1111;
    end else begin
`ifdef DISP_ARBITER_BLANK_LEAD_EN
      if (lead_zero(sel_s, idx_s)) begin
        an_s = 4'b1111;
      end else begin
        an_s = ~(4'b0001 << idx_s);
      end
`else
      an_s = ~(4'b0001 << idx_s);
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      hold_r  <= '0;
      scan_r  <= '0;
      idx_r   <= 2'd0;
      last_r  <= 1'b1;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      off     <= 1'b0;
      an      <= 4'b1111;
      digit   <= 4'h0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      scan_r  <= scan_s;
      idx_r   <= idx_s;
      last_r  <= last_s;
      gnt_a   <= (state_s == GNT_A);
      gnt_b   <= (state_s == GNT_B);
      off     <= off_s;
      an      <= an_s;
      digit   <= (state_s == IDLE) ? 4'h0 : nib_s;
      busy    <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter
// Self-checking bench for disp_arbiter (HOLD_CYCLES=4, SCAN_CYCLES=2).
// Directed scenarios followed by randomized requests, digits and resets,
// all compared against an ownership/tick reference model.
// Honors DISP_ARBITER_BLANK_LEAD_EN for the blanking scenarios.
module tb_disp_arbiter;

  localparam int HOLD = 4;
  localparam int SCAN = 2;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic        req_b;
  logic [15:0] dig_a;
  logic [15:0] dig_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        off;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        busy;

  int checks_r;
  int errors_r;

  // Reference model: owner 0 = none, 1 = A, 2 = B.
  int owner;
  int held;
  int tick;
  bit m_last;
  bit m_off;
  logic [3:0] exp_an;
  logic [3:0] exp_digit;

  disp_arbiter #(
    .HOLD_CYCLES (HOLD),
    .SCAN_CYCLES (SCAN)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .dig_a (dig_a),
    .dig_b (dig_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .off   (off),
    .an    (an),
    .digit (digit),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic grant(input int who);
    owner  = who;
    held   = 0;
    tick   = 0;
    m_last = (who == 2);
    m_off  = (who == 2);
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    logic [15:0] val;
    int k;
    bit mine;
    bit other;
    if (rst) begin
      owner = 0; held = 0; tick = 0; m_last = 1'b1; m_off = 1'b0;
    end else if (owner == 0) begin
      if (req_a && req_b) grant(m_last ? 1 : 2);
      else if (req_a) grant(1);
      else if (req_b) grant(2);
    end else begin
      mine  = (owner == 1) ? req_a : req_b;
      other = (owner == 1) ? req_b : req_a;
      if (held >= HOLD - 1 && other) grant(3 - owner);
      else if (held >= HOLD - 1 && !mine) owner = 0;
      else begin
        held++;
        tick++;
      end
    end
    if (owner == 0) begin
      exp_an    = 4'b1111;
      exp_digit = 4'h0;
    end else begin
      k         = (tick / SCAN) % 4;
      val       = m_off ? dig_b : dig_a;
      exp_digit = 4'((val >> (4 * k)) & 16'h000F);
      exp_an    = 4'((~(32'd1 << k)) & 32'hF);
`ifdef DISP_ARBITER_BLANK_LEAD_EN
      if (k > 0 && (val >> (4 * k)) == 16'h0000) exp_an = 4'b1111;
`endif
    end
  endtask

  // One clock: model update at the edge, DUT compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt_a", {15'd0, gnt_a}, {15'd0, owner == 1});
    chk("gnt_b", {15'd0, gnt_b}, {15'd0, owner == 2});
    chk("busy",  {15'd0, busy},  {15'd0, owner != 0});
    chk("off",   {15'd0, off},   {15'd0, m_off});
    chk("an",    {12'd0, an},    {12'd0, exp_an});
    chk("digit", {12'd0, digit}, {12'd0, exp_digit});
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    owner = 0; held = 0; tick = 0; m_last = 1'b1; m_off = 1'b0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    dig_a = 16'h0000; dig_b = 16'h0000;
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_busy", {15'd0, busy}, 16'h0000);

    // A alone with 0x1234: scan 4,3,2,1 repeating.
    dig_a = 16'h1234; dig_b = 16'hABCD; req_a = 1'b1;
    step();
    chk("a_first_gnt", {15'd0, gnt_a}, 16'h0001);
    chk("a_first_an", {12'd0, an}, 16'h000E);
    chk("a_first_digit", {12'd0, digit}, 16'h0004);
    for (int i = 0; i < 15; i++) step();

    // Both requesting from reset: A, then B, then A with no idle gap.
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rr_a_held", {15'd0, gnt_a}, 16'h0001);
    step();
    chk("rr_b_switch", {15'd0, gnt_b}, 16'h0001);
    chk("rr_b_off", {15'd0, off}, 16'h0001);
    for (int i = 0; i < 3; i++) step();
    step();
    chk("rr_a_again", {15'd0, gnt_a}, 16'h0001);

    // B pulsed once: held exactly HOLD cycles, then idle with off kept.
    do_reset();
    req_b = 1'b1;
    step();
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pulse_b_held", {15'd0, gnt_b}, 16'h0001);
    step();
    chk("pulse_idle_an", {12'd0, an}, 16'h000F);
    chk("pulse_idle_off", {15'd0, off}, 16'h0001);
    for (int i = 0; i < 3; i++) step();

    // Reset during B at scan index 2, then A wins the tie.
    do_reset();
    req_b = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_idx2_an", {12'd0, an}, 16'h000B);
    rst = 1'b1; req_a = 1'b1;
    step();
    chk("mid_rst_gnt_b", {15'd0, gnt_b}, 16'h0000);
    chk("mid_rst_off", {15'd0, off}, 16'h0000);
    rst = 1'b0;
    step();
    chk("post_rst_gnt_a", {15'd0, gnt_a}, 16'h0001);

    // Live digit swap.
    do_reset();
    dig_a = 16'h1111; req_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    dig_a = 16'h2222;
    step();
    chk("swap_digit", {12'd0, digit}, 16'h0002);

    // Leading-zero values (blanked only when the macro is defined).
    dig_a = 16'h0042;
    for (int i = 0; i < 10; i++) step();
    dig_a = 16'h0000;
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) req_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) dig_a = 16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF);
      if ($urandom_range(0, 7) == 0) dig_b = 16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h000F);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
